bus_arb: RTL and testbench

- Arbitrates the CPU's external memory bus (AB/DO/WE) between the 65C02 core and NREQ DMA requesters.
- Sits between cpu and the memory system and drives the CPU's RDY input to stall it while a DMA owns the bus.
- Grants are round-robin with a bounded burst length and a guaranteed CPU window between bursts, so neither side can starve.

---
 rtl/bus_arb_pkg.sv | 21 ++
 rtl/bus_arb_rr_pick.sv | 31 +++
 rtl/bus_arb.sv | 132 +++++++++++++
 tb/tb_bus_arb.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared definitions for the external-bus arbiter: FSM encoding, owner codes
// and counter sizing.
package bus_arb_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_CPU      = 2'd0,
        ST_HANDOVER = 2'd1,
        ST_DMA      = 2'd2,
        ST_GUARD    = 2'd3
    } state_e;

    localparam logic [1:0] OWN_CPU = 2'd0;

    // Pointer/winner width: ceil(log2(n)), never narrower than one bit.
    function automatic int ptr_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bus_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or after the
// pointer, scanning upward and wrapping modulo NREQ.
module rr_pick
    import bus_arb_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int PTR_W = ptr_width(NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [PTR_W-1:0] win_o,
    output logic             vld_o
);

    logic [PTR_W-1:0] idx;

    // Scan from the far end back toward the pointer so the closest hit wins.
    always_comb begin
        win_o = '0;
        vld_o = 1'b0;
        idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = PTR_W'((int'(ptr_i) + k) % NREQ);
            if (req_i[idx]) begin
                win_o = idx;
                vld_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arb.sv
// Arbitrates the 65C02 external bus between the CPU and NREQ DMA requesters,
// stalling the CPU through RDY while a DMA burst owns the bus.
module bus_arb
    import bus_arb_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int MAX_BURST = 4,
    parameter int CPU_MIN   = 2
) (
    input  logic                 clk,
    input  logic                 RST,
    input  logic [15:0]          cpu_ab,
    input  logic [7:0]           cpu_do,
    input  logic                 cpu_we,
    output logic                 RDY,
    input  logic [NREQ-1:0]      req,
    output logic [NREQ-1:0]      gnt,
    input  logic [16*NREQ-1:0]   dma_ab,
    input  logic [8*NREQ-1:0]    dma_do,
    input  logic [NREQ-1:0]      dma_we,
    output logic [15:0]          AB,
    output logic [7:0]           DO,
    output logic                 WE,
    output logic [1:0]           owner
);

    localparam int PTR_W = ptr_width(NREQ);

    state_e             state_q;
    logic               rdy_q;
    logic [NREQ-1:0]    gnt_q;
    logic [1:0]         owner_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   win_q;
    logic [CNT_W-1:0]   burst_q;
    logic [CNT_W-1:0]   guard_q;

    logic [PTR_W-1:0]   ptr_d;
    logic [CNT_W-1:0]   burst_d;
    logic [CNT_W-1:0]   guard_d;
    logic [PTR_W-1:0]   pick_win;
    logic               pick_vld;
    logic               burst_end;

    rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req_i (req),
        .ptr_i (ptr_q),
        .win_o (pick_win),
        .vld_o (pick_vld)
    );

    // A dropped request ends the burst at the edge where it is first seen low.
    assign burst_end = !req[win_q] || (burst_q == CNT_W'(MAX_BURST));
    assign burst_d   = burst_q + 1'b1;
    assign guard_d   = guard_q - 1'b1;
    assign ptr_d     = (int'(win_q) == NREQ - 1) ? '0 : win_q + 1'b1;

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q <= ST_CPU;
            rdy_q   <= 1'b1;
            gnt_q   <= '0;
            owner_q <= OWN_CPU;
            ptr_q   <= '0;
            win_q   <= '0;
            burst_q <= '0;
            guard_q <= '0;
        end else begin
            case (state_q)
                ST_CPU: begin
                    // Never stall the core in the middle of a write cycle.
                    if (|req && !cpu_we && guard_q == '0) begin
                        state_q <= ST_HANDOVER;
                        rdy_q   <= 1'b0;
                    end
                end
                ST_HANDOVER: begin
                    if (pick_vld) begin
                        state_q <= ST_DMA;
                        gnt_q   <= NREQ'(1) << pick_win;
                        owner_q <= 2'(pick_win) + 2'd1;
                        win_q   <= pick_win;
                        burst_q <= CNT_W'(1);
                    end else begin
                        state_q <= ST_CPU;
                        rdy_q   <= 1'b1;
                    end
                end
                ST_DMA: begin
                    if (burst_end) begin
                        state_q <= ST_GUARD;
                        gnt_q   <= '0;
                        owner_q <= OWN_CPU;
                        rdy_q   <= 1'b1;
                        ptr_q   <= ptr_d;
                        guard_q <= CNT_W'(CPU_MIN);
                    end else begin
                        burst_q <= burst_d;
                    end
                end
                ST_GUARD: begin
                    if (guard_q <= CNT_W'(1)) begin
                        guard_q <= '0;
                        state_q <= ST_CPU;
                    end else begin
                        guard_q <= guard_d;
                    end
                end
                default: state_q <= ST_CPU;
            endcase
        end
    end

    assign RDY   = rdy_q;
    assign gnt   = gnt_q;
    assign owner = owner_q;

    always_comb begin
        AB = cpu_ab;
        DO = cpu_do;
        WE = cpu_we;
        if (owner_q != OWN_CPU) begin
            AB = dma_ab[16*win_q +: 16];
            DO = dma_do[8*win_q +: 8];
            WE = dma_we[win_q];
        end
    end

endmodule

// File: tb/tb_bus_arb.sv
// Self-checking bench for bus_arb: per-cycle scoreboard from a reference model
// plus scenario checks, and a standalone sweep of rr_pick.
module tb_bus_arb;

    localparam int NREQ      = 2;
    localparam int MAX_BURST = 4;
    localparam int CPU_MIN   = 2;
    localparam int S_CPU = 0, S_HO = 1, S_DMA = 2, S_GRD = 3;

    logic               clk;
    logic               RST;
    logic [15:0]        cpu_ab;
    logic [7:0]         cpu_do;
    logic               cpu_we;
    logic               RDY;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    gnt;
    logic [16*NREQ-1:0] dma_ab;
    logic [8*NREQ-1:0]  dma_do;
    logic [NREQ-1:0]    dma_we;
    logic [15:0]        AB;
    logic [7:0]         DO;
    logic               WE;
    logic [1:0]         owner;

    logic [2:0]         rr_req;
    logic [1:0]         rr_ptr;
    logic [1:0]         rr_win;
    logic               rr_vld;

    bus_arb #(.NREQ(NREQ), .MAX_BURST(MAX_BURST), .CPU_MIN(CPU_MIN)) dut (
        .clk(clk), .RST(RST), .cpu_ab(cpu_ab), .cpu_do(cpu_do), .cpu_we(cpu_we),
        .RDY(RDY), .req(req), .gnt(gnt), .dma_ab(dma_ab), .dma_do(dma_do),
        .dma_we(dma_we), .AB(AB), .DO(DO), .WE(WE), .owner(owner)
    );

    rr_pick #(.NREQ(3), .PTR_W(2)) u_rr (
        .req_i(rr_req), .ptr_i(rr_ptr), .win_o(rr_win), .vld_o(rr_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rdy;
        logic [1:0]  gnt;
        logic [1:0]  own;
        logic [15:0] ab;
        logic [7:0]  dat;
        logic        we;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc_n = 0;

    int          m_st, m_ptr, m_burst, m_guard, m_win, m_own;
    logic        m_rdy;
    logic [1:0]  m_gnt;

    logic        o_rdy, o_we;
    logic [1:0]  o_gnt, o_own;
    logic [15:0] o_ab;
    logic [7:0]  o_do;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_st = S_CPU; m_rdy = 1'b1; m_gnt = '0; m_own = 0;
        m_ptr = 0; m_burst = 0; m_guard = 0; m_win = 0;
    endtask

    task automatic model_clock();
        bit found;
        if (!RST) begin
            model_reset();
        end else begin
            case (m_st)
                S_CPU: if (req != 0 && !cpu_we && m_guard == 0) begin
                    m_st = S_HO; m_rdy = 1'b0;
                end
                S_HO: begin
                    found = 0;
                    for (int k = 0; k < NREQ; k++) begin
                        int c;
                        c = (m_ptr + k) % NREQ;
                        if (!found && req[c]) begin found = 1; m_win = c; end
                    end
                    if (found) begin
                        m_st = S_DMA; m_gnt = 2'(1 << m_win); m_own = m_win + 1; m_burst = 1;
                    end else begin
                        m_st = S_CPU; m_rdy = 1'b1;
                    end
                end
                S_DMA: begin
                    if (!req[m_win] || m_burst == MAX_BURST) begin
                        m_st = S_GRD; m_gnt = '0; m_own = 0; m_rdy = 1'b1;
                        m_ptr = (m_win + 1) % NREQ; m_guard = CPU_MIN;
                    end else begin
                        m_burst++;
                    end
                end
                default: begin
                    m_guard--;
                    if (m_guard == 0) m_st = S_CPU;
                end
            endcase
        end
    endtask

    // One bus cycle: drive inputs, queue the expected bus, check mid-cycle.
    task automatic cyc(input logic [NREQ-1:0] r, input logic we, input logic [15:0] a, input logic [7:0] d);
        exp_t e;
        req = r; cpu_we = we; cpu_ab = a; cpu_do = d;
        e.rdy = m_rdy; e.gnt = m_gnt; e.own = 2'(m_own);
        if (m_own == 0) begin
            e.ab = a; e.dat = d; e.we = we;
        end else begin
            e.ab = dma_ab[16*(m_own-1) +: 16]; e.dat = dma_do[8*(m_own-1) +: 8]; e.we = dma_we[m_own-1];
        end
        exp_q.push_back(e);
        @(negedge clk);
        o_rdy = RDY; o_gnt = gnt; o_own = owner; o_ab = AB; o_do = DO; o_we = WE;
        e = exp_q.pop_front();
        check_eq($sformatf("c%0d.RDY", cyc_n), 32'(o_rdy), 32'(e.rdy));
        check_eq($sformatf("c%0d.gnt", cyc_n), 32'(o_gnt), 32'(e.gnt));
        check_eq($sformatf("c%0d.owner", cyc_n), 32'(o_own), 32'(e.own));
        check_eq($sformatf("c%0d.AB", cyc_n), 32'(o_ab), 32'(e.ab));
        check_eq($sformatf("c%0d.DO", cyc_n), 32'(o_do), 32'(e.dat));
        check_eq($sformatf("c%0d.WE", cyc_n), 32'(o_we), 32'(e.we));
        model_clock();
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc('0, 1'b0, 16'h1234, 8'h00);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        t_rdy[30];
        logic [1:0]  t_gnt[30];
        logic [15:0] t_ab[30];
        int          gs, len, ab_ok, gap, nstart, first0, gcnt;
        logic [1:0]  starts[4];
        bit          v;
        int          w;

        RST = 1'b1; req = '0; cpu_we = 1'b0; cpu_ab = 16'h0000; cpu_do = 8'h00;
        dma_ab = {16'hB222, 16'hA111}; dma_do = {8'hB2, 8'hA1}; dma_we = 2'b10;
        rr_req = '0; rr_ptr = '0;
        model_reset();

        // rr_pick standalone sweep with NREQ=3 so wrap-around is exercised
        for (int p = 0; p < 3; p++) begin
            for (int r = 0; r < 8; r++) begin
                rr_req = 3'(r); rr_ptr = 2'(p);
                #1;
                v = 0; w = 0;
                for (int k = 0; k < 3; k++) begin
                    int c;
                    c = (p + k) % 3;
                    if (!v && rr_req[c]) begin v = 1; w = c; end
                end
                check_eq($sformatf("rr r%0d p%0d vld", r, p), 32'(rr_vld), 32'(v));
                if (v) check_eq($sformatf("rr r%0d p%0d win", r, p), 32'(rr_win), 32'(w));
            end
        end

        #2 RST = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst.RDY", 32'(RDY), 32'd1);
        check_eq("rst.gnt", 32'(gnt), 32'd0);
        check_eq("rst.owner", 32'(owner), 32'd0);
        RST = 1'b1;
        idle(3);

        // req=01 held with CPU reads
        for (int i = 0; i < 30; i++) begin
            cyc(2'b01, 1'b0, 16'h2000 + 16'(i), 8'h00);
            t_rdy[i] = o_rdy; t_gnt[i] = o_gnt; t_ab[i] = o_ab;
        end
        first0 = -1;
        for (int i = 29; i >= 0; i--) if (!t_rdy[i]) first0 = i;
        check_eq("t1.rdy_fall_cycle", 32'(first0), 32'd1);
        gs = -1;
        for (int i = 29; i >= 0; i--) if (t_gnt[i] == 2'b01) gs = i;
        len = 0; ab_ok = 0;
        if (gs >= 0) begin
            for (int i = gs; i < 30 && t_gnt[i] == 2'b01; i++) begin
                len++;
                if (t_ab[i] == 16'hA111) ab_ok++;
            end
        end
        check_eq("t1.burst_len", 32'(len), 32'(MAX_BURST));
        check_eq("t1.burst_ab", 32'(ab_ok), 32'(MAX_BURST));
        gap = 0;
        if (gs >= 0) for (int i = gs + len; i < 30 && t_rdy[i]; i++) gap++;
        check_eq("t1.cpu_gap_ge_min", 32'(gap >= CPU_MIN), 32'd1);
        check_eq("t1.next_handover", 32'(gs >= 0 && gs + len + gap < 30 && !t_rdy[gs+len+gap]), 32'd1);
        idle(8);

        // async reset mid-burst while the pointer sits at 1
        cyc(2'b01, 1'b0, 16'h3000, 8'h00);
        cyc(2'b01, 1'b0, 16'h3000, 8'h00);
        cyc(2'b01, 1'b0, 16'h3000, 8'h00);
        check_eq("t5.pre_gnt", 32'(o_gnt), 32'd1);
        RST = 1'b0;
        #2;
        check_eq("t5.RDY", 32'(RDY), 32'd1);
        check_eq("t5.gnt", 32'(gnt), 32'd0);
        check_eq("t5.owner", 32'(owner), 32'd0);
        check_eq("t5.AB", 32'(AB), 32'h3000);
        model_reset();
        cyc(2'b11, 1'b0, 16'h3100, 8'h00);
        RST = 1'b1;

        // req=11 held: alternating grants starting from requester 0
        nstart = 0;
        for (int i = 0; i < 30; i++) begin
            cyc(2'b11, 1'b0, 16'h4000 + 16'(i), 8'h00);
            t_gnt[i] = o_gnt;
            if (o_gnt != 0 && (i == 0 || t_gnt[i-1] == 0) && nstart < 4) begin
                starts[nstart] = o_gnt;
                nstart++;
            end
        end
        check_eq("t2.nbursts", 32'(nstart >= 3), 32'd1);
        if (nstart >= 3) begin
            check_eq("t2.burst0", 32'(starts[0]), 32'h1);
            check_eq("t2.burst1", 32'(starts[1]), 32'h2);
            check_eq("t2.burst2", 32'(starts[2]), 32'h1);
        end
        idle(8);

        // request arrives during a three-write push sequence
        cyc(2'b01, 1'b1, 16'h01FF, 8'h20);
        check_eq("t3.w0", 32'({o_rdy, o_we, o_ab, o_do}), 32'({1'b1, 1'b1, 16'h01FF, 8'h20}));
        cyc(2'b01, 1'b1, 16'h01FE, 8'h34);
        check_eq("t3.w1", 32'({o_rdy, o_we, o_ab, o_do}), 32'({1'b1, 1'b1, 16'h01FE, 8'h34}));
        cyc(2'b01, 1'b1, 16'h01FD, 8'h56);
        check_eq("t3.w2", 32'({o_rdy, o_we, o_ab, o_do}), 32'({1'b1, 1'b1, 16'h01FD, 8'h56}));
        cyc(2'b01, 1'b0, 16'h0300, 8'h00);
        check_eq("t3.read_rdy", 32'(o_rdy), 32'd1);
        cyc(2'b01, 1'b0, 16'h0300, 8'h00);
        check_eq("t3.rdy_drop", 32'(o_rdy), 32'd0);
        for (int i = 0; i < 6; i++) cyc(2'b01, 1'b0, 16'h0300, 8'h00);
        idle(8);

        // requester 1 drops req during its second transfer
        gcnt = 0; ab_ok = 0;
        for (int i = 0; i < 6; i++) begin
            cyc((i < 3) ? 2'b10 : 2'b00, 1'b0, 16'h5000, 8'h00);
            if (o_gnt == 2'b10) begin
                gcnt++;
                if (o_ab == 16'hB222 && o_we) ab_ok++;
            end
            if (i == 4) begin
                check_eq("t4.after_gnt", 32'(o_gnt), 32'd0);
                check_eq("t4.after_owner", 32'(o_own), 32'd0);
                check_eq("t4.after_rdy", 32'(o_rdy), 32'd1);
            end
        end
        check_eq("t4.transfers", 32'(gcnt), 32'd2);
        check_eq("t4.dma_bus", 32'(ab_ok), 32'd2);
        idle(8);

        // one-cycle request pulse collapses in HANDOVER
        cyc(2'b01, 1'b0, 16'h4567, 8'h00);
        cyc(2'b00, 1'b0, 16'h4567, 8'h00);
        check_eq("t6.dip_rdy", 32'(o_rdy), 32'd0);
        check_eq("t6.dip_ab", 32'(o_ab), 32'h4567);
        cyc(2'b00, 1'b0, 16'h4567, 8'h00);
        check_eq("t6.resume_rdy", 32'(o_rdy), 32'd1);
        check_eq("t6.no_gnt", 32'(o_gnt), 32'd0);
        cyc(2'b00, 1'b0, 16'h4567, 8'h00);
        check_eq("t6.still_no_gnt", 32'(o_gnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
